// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the 8N1 UART receiver/transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Modulo-CLKS_PER_BIT bit-period counter; ticks are combinational from the count, zero latency.
// Held at zero while clr is high, so the first cycle after clr drops is cycle 0 of a bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic mid_tick,
  output logic end_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign mid_tick = !clr && (cnt_q == MID_CNT);
  assign end_tick = !clr && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || end_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_buf_tx.sv
// 8N1 UART: synchronised receiver feeding a one-byte holding buffer, plus an independent transmitter.
// rx_ready/rx_byte update one clock after the stop-bit sample; no backpressure, new bytes overwrite.
module uart_rx_buf_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_ready,
  output logic                 rx_frame_err,
  input  logic [DATA_BITS-1:0] tx_byte,
  input  logic                 tx_enable,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_s_q;
  rx_state_t            rx_state_q, rx_state_d;
  logic [IW-1:0]        rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_frame_err_q, rx_frame_err_d;
  logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 rx_tmr_clr, rx_mid, rx_end_unused;

  tx_state_t            tx_state_q, tx_state_d;
  logic [IW-1:0]        tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_tmr_clr, tx_end, tx_mid_unused;

  // The receive timer only runs once a start edge is seen, so mid_tick lands mid-bit.
  assign rx_tmr_clr = (rx_state_q == RX_IDLE) || (rx_state_q == RX_WAIT_HIGH);
  assign tx_tmr_clr = (tx_state_q == TX_IDLE);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (rx_tmr_clr),
    .mid_tick (rx_mid),
    .end_tick (rx_end_unused)
  );

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (tx_tmr_clr),
    .mid_tick (tx_mid_unused),
    .end_tick (tx_end)
  );

  always_comb begin
    rx_state_d     = rx_state_q;
    rx_idx_d       = rx_idx_q;
    rx_shift_d     = rx_shift_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE:      if (!rx_s_q) rx_state_d = RX_START;
      RX_START: begin
        if (rx_mid) begin
          rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
          rx_idx_d   = '0;
        end
      end
      RX_DATA: begin
        if (rx_mid) begin
          rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
          rx_idx_d   = rx_idx_q + IW'(1);
          if (rx_idx_q == LAST_BIT) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_mid) begin
          rx_valid_d     = rx_s_q;
          rx_frame_err_d = !rx_s_q;
          rx_state_d     = rx_s_q ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: if (rx_s_q) rx_state_d = RX_IDLE;
      default:      rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_byte_d  = rx_valid_q ? rx_shift_q : rx_byte_q;
    rx_ready_d = rx_valid_q;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_enable) begin
          tx_shift_d = tx_byte;
          tx_busy_d  = 1'b1;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_end) begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
          tx_idx_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_end) begin
          if (tx_idx_q == LAST_BIT) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            tx_idx_d   = tx_idx_q + IW'(1);
          end
        end
      end
      TX_STOP: begin
        if (tx_end) begin
          tx_busy_d  = 1'b0;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q      <= 1'b1;
      rx_s_q         <= 1'b1;
      rx_state_q     <= RX_IDLE;
      rx_idx_q       <= '0;
      rx_shift_q     <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_byte_q      <= '0;
      rx_ready_q     <= 1'b0;
      tx_state_q     <= TX_IDLE;
      tx_idx_q       <= '0;
      tx_shift_q     <= '0;
      tx_q           <= 1'b1;
      tx_busy_q      <= 1'b0;
    end else begin
      rx_meta_q      <= rx;
      rx_s_q         <= rx_meta_q;
      rx_state_q     <= rx_state_d;
      rx_idx_q       <= rx_idx_d;
      rx_shift_q     <= rx_shift_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
      rx_byte_q      <= rx_byte_d;
      rx_ready_q     <= rx_ready_d;
      tx_state_q     <= tx_state_d;
      tx_idx_q       <= tx_idx_d;
      tx_shift_q     <= tx_shift_d;
      tx_q           <= tx_d;
      tx_busy_q      <= tx_busy_d;
    end
  end

  assign rx_byte      = rx_byte_q;
  assign rx_ready     = rx_ready_q;
  assign rx_frame_err = rx_frame_err_q;
  assign tx           = tx_q;
  assign tx_busy      = tx_busy_q;

endmodule

// File: tb/tb_uart_rx_buf_tx.sv
// Scoreboard bench for uart_rx_buf_tx: stimulus pushes expected bytes/errors, monitors pop and compare.
module tb_uart_rx_buf_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_drv;
  logic       loopback;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic       rx_frame_err;
  logic [7:0] tx_byte;
  logic       tx_enable;
  logic       tx;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];
  int         exp_err_cnt = 0;
  logic [7:0] model_rx_byte = 8'h00;
  bit         rx_mon_en = 1'b0;
  bit         tx_mon_en = 1'b0;
  logic [7:0] rx_pop;
  logic [7:0] rnd_b;
  bit         rnd_st;

  always #5 clk = ~clk;

  assign rx = loopback ? tx : rx_drv;

  uart_rx_buf_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_byte      (rx_byte),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .tx_byte      (tx_byte),
    .tx_enable    (tx_enable),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Receive-side monitor: every strobe must match an outstanding expectation.
  always @(negedge clk) begin
    if (rx_mon_en) begin
      if (rx_ready === 1'b1) begin
        if (exp_rx_q.size() == 0) begin
          check("rx_ready_unexpected", 32'(rx_ready), 32'h0);
        end else begin
          rx_pop = exp_rx_q.pop_front();
          check("rx_byte", 32'(rx_byte), 32'(rx_pop));
        end
      end
      if (rx_frame_err === 1'b1) begin
        if (exp_err_cnt == 0) begin
          check("rx_frame_err_unexpected", 32'(rx_frame_err), 32'h0);
        end else begin
          exp_err_cnt--;
          check("err_without_ready", 32'(rx_ready), 32'h0);
        end
      end
    end
  end

  // Transmit-side line decoder: mid-bit sampling of each frame seen on tx.
  always begin
    @(negedge clk);
    if (tx_mon_en && tx === 1'b0) begin : dec
      logic [7:0] d;
      bit ok;
      ok = 1'b1;
      d = 8'h00;
      repeat (CPB / 2) @(negedge clk);
      if (!tx_mon_en) ok = 1'b0;
      else check("tx_start_bit", 32'(tx), 32'h0);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        if (!tx_mon_en) ok = 1'b0;
        d[k] = tx;
      end
      repeat (CPB) @(negedge clk);
      if (ok && tx_mon_en) begin
        check("tx_stop_bit", 32'(tx), 32'h1);
        if (exp_tx_q.size() == 0) check("tx_frame_unexpected", 32'(d), 32'h100);
        else check("tx_byte_serial", 32'(d), 32'(exp_tx_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    rx_drv = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx_drv = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input bit push);
    if (push) begin
      if (stop_bit) begin
        exp_rx_q.push_back(b);
        model_rx_byte = b;
      end else begin
        exp_err_cnt++;
      end
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic wait_tx_idle(input int budget);
    int n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("tx_busy_timeout", 32'(tx_busy), 32'h0);
  endtask

  task automatic tx_send(input logic [7:0] b);
    wait_tx_idle(100);
    tx_byte   = b;
    tx_enable = 1'b1;
    exp_tx_q.push_back(b);
    @(negedge clk);
    tx_enable = 1'b0;
    tx_byte   = 8'($urandom);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_rx_q.size() != 0 || exp_tx_q.size() != 0 || exp_err_cnt != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_rx_q.size() + exp_tx_q.size() + exp_err_cnt), 32'h0);
  endtask

  // Cycle-exact waveform check: offset 0 is the first sample after the accepting edge.
  task automatic tx_directed(input logic [7:0] b);
    int bad = 0;
    int busy_n = 0;
    logic exp_bit;
    tx_byte   = b;
    tx_enable = 1'b1;
    exp_tx_q.push_back(b);
    @(negedge clk);
    tx_enable = 1'b0;
    for (int o = 0; o < 44; o++) begin
      if (o > 0) @(negedge clk);
      if (o < 4)       exp_bit = 1'b0;
      else if (o < 36) exp_bit = b[(o - 4) / 4];
      else             exp_bit = 1'b1;
      if (tx !== exp_bit) bad++;
      if (tx_busy === 1'b1) busy_n++;
    end
    check("tx_wave_mismatches", 32'(bad), 32'h0);
    check("tx_busy_len", 32'(busy_n), 32'd40);
  endtask

  initial begin
    int n;
    int lowc;
    logic [7:0] lb;
    reset     = 1'b1;
    rx_drv    = 1'b1;
    loopback  = 1'b0;
    tx_enable = 1'b0;
    tx_byte   = 8'h00;
    #2 reset  = 1'b0;
    #10;
    check("reset_rx_byte", 32'(rx_byte), 32'h0);
    check("reset_rx_ready", 32'(rx_ready), 32'h0);
    check("reset_rx_frame_err", 32'(rx_frame_err), 32'h0);
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_tx_busy", 32'(tx_busy), 32'h0);
    @(negedge clk);
    reset     = 1'b1;
    rx_mon_en = 1'b1;
    tx_mon_en = 1'b1;

    idle(8);
    send_rx(8'hA9, 1'b1, 1'b1);
    idle(4);
    wait_drain(200);
    check("rx_byte_hold_a9", 32'(rx_byte), 32'(model_rx_byte));

    send_rx(8'h3C, 1'b0, 1'b1);
    idle(6);
    wait_drain(200);
    check("rx_byte_after_err", 32'(rx_byte), 32'(model_rx_byte));
    send_rx(8'h5A, 1'b1, 1'b1);
    idle(4);
    wait_drain(200);

    rx_drv = 1'b0;
    @(negedge clk);
    idle(12);
    check("false_start_byte_kept", 32'(rx_byte), 32'(model_rx_byte));
    send_rx(8'h81, 1'b1, 1'b1);
    idle(4);
    wait_drain(200);

    tx_directed(8'h55);
    wait_drain(100);

    tx_byte   = 8'h0F;
    tx_enable = 1'b1;
    exp_tx_q.push_back(8'h0F);
    @(negedge clk);
    tx_enable = 1'b0;
    repeat (10) @(negedge clk);
    tx_byte   = 8'hF0;
    tx_enable = 1'b1;
    @(negedge clk);
    tx_enable = 1'b0;
    wait_tx_idle(100);
    repeat (30) @(negedge clk);
    check("tx_no_restart", 32'(tx_busy), 32'h0);
    wait_drain(100);

    // Level-held enable: exactly one idle cycle between back-to-back frames.
    lb        = 8'($urandom);
    tx_byte   = lb;
    tx_enable = 1'b1;
    exp_tx_q.push_back(lb);
    exp_tx_q.push_back(lb);
    n = 0;
    while (tx_busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (tx_busy !== 1'b0 && n < 60) begin @(negedge clk); n++; end
    lowc = 0;
    while (tx_busy !== 1'b1 && lowc < 10) begin lowc++; @(negedge clk); end
    tx_enable = 1'b0;
    check("tx_level_gap", 32'(lowc), 32'd1);
    wait_drain(120);

    fork
      begin
        for (int i = 0; i < 12; i++) begin
          rnd_b  = 8'($urandom);
          rnd_st = ($urandom_range(0, 4) != 0);
          send_rx(rnd_b, rnd_st, 1'b1);
          idle(rnd_st ? int'($urandom_range(0, 5)) : int'($urandom_range(2, 6)));
        end
      end
      begin
        for (int j = 0; j < 10; j++) begin
          repeat ($urandom_range(0, 8)) @(negedge clk);
          tx_send(8'($urandom));
        end
      end
    join
    idle(6);
    wait_drain(300);

    tx_mon_en = 1'b0;
    tx_byte   = 8'hE7;
    tx_enable = 1'b1;
    @(negedge clk);
    tx_enable = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    reset = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 32'h1);
    check("rst_tx_busy", 32'(tx_busy), 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'h0);
    check("rst_rx_frame_err", 32'(rx_frame_err), 32'h0);
    rx_drv   = 1'b1;
    loopback = 1'b1;
    @(negedge clk);
    check("rst_rx_byte", 32'(rx_byte), 32'h0);
    reset     = 1'b1;
    tx_mon_en = 1'b1;
    repeat (4) @(negedge clk);
    exp_rx_q.push_back(8'hC3);
    model_rx_byte = 8'hC3;
    tx_send(8'hC3);
    wait_drain(200);
    check("loopback_rx_byte", 32'(rx_byte), 32'h0C3);
    loopback = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_buf_tx.md
Name: uart_rx_buf_tx

Overview:
Byte-level 8N1 UART link block with three stages: a serial receiver, a one-byte output holding buffer, and an independent serial transmitter. The receiver deserialises frames from the line. The buffer presents each received byte with a one-cycle strobe to downstream processing (for example an encoder). The transmitter serialises a byte supplied by upstream logic when enabled.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit (≥2; must be even).
DATA_BITS, 8, data bits per frame (fixed at 8 in this release).

Ports:
clk  in  1  single system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
rx  in  1  serial input; idle high.
rx_byte  out  8  buffered received byte; held until the next byte.
rx_ready  out  1  one-cycle strobe: rx_byte has just been updated.
rx_frame_err  out  1  one-cycle strobe: stop bit sampled low.
tx_byte  in  8  byte to transmit; sampled on accepted tx_enable.
tx_enable  in  1  transmit request, one cycle or level.
tx  out  1  serial output; idle high.
tx_busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (reset=0, async):
  - rx_byte=0, rx_ready=0, rx_frame_err=0.
  - tx=1, tx_busy=0.
  - All counters clear; both FSMs return to IDLE.
  - Reset mid-frame aborts the frame: nothing is delivered and tx returns high immediately.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts CLKS_PER_BIT clocks.
- rx passes through a 2-flop synchronizer (rx_s). Synchronizer flops reset to 1.
- Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 -> START, counter=0.
  - START: at count CLKS_PER_BIT/2-1 (mid-bit), sample rx_s.
    - rx_s==1: false start -> IDLE.
    - rx_s==0: -> DATA.
  - DATA: sample every CLKS_PER_BIT clocks at mid-bit. Shift each sample into bit position 0..7 in arrival order (LSB first). After bit 7 -> STOP.
  - STOP: sample at mid-bit.
    - rx_s==1: assert internal rx_valid for one cycle with the assembled byte -> IDLE.
    - rx_s==0: pulse rx_frame_err for one cycle, no byte -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then -> IDLE.
  - A new start is accepted immediately after the stop-bit sample; it does not wait for the stop-bit end.
- Buffer: on rx_valid, register the byte into rx_byte and pulse rx_ready one cycle later.
  - Latency: rx_ready is 1 clock after rx_valid.
  - rx_byte holds its value until overwritten; there is no backpressure.
  - Back-to-back frames overwrite. This cannot lose data since frames are ≥10·CLKS_PER_BIT apart.
- Transmitter FSM states: IDLE, START, DATA, STOP.
  - IDLE with tx_enable=1: latch tx_byte and set tx_busy=1 on that same edge; tx=0 from that edge (start bit).
  - tx_enable while tx_busy=1 is ignored; the latched byte is unaffected.
  - Each bit is held exactly CLKS_PER_BIT clocks. Data goes out LSB first, then stop bit 1.
  - tx_busy falls on the edge that ends the stop bit.
  - tx_enable high on that same cycle is not accepted. The earliest next start is the following cycle, giving a frame period ≥10·CLKS_PER_BIT+1 clocks.
- Receiver and transmitter are fully independent and may operate simultaneously.
- All outputs are registered.

Decomposition:
- Package uart_pkg holds:
  - DATA_BITS constant.
  - rx_state_t enum {IDLE, START, DATA, STOP, WAIT_HIGH}.
  - tx_state_t enum {IDLE, START, DATA, STOP}.
- One sub-module, uart_bit_timer: modulo-CLKS_PER_BIT counter with clear input, a mid-bit tick, and an end-of-bit tick. It is instantiated once in the receiver path and once in the transmitter path.
- Receiver, buffer and transmitter FSMs live in the top module.

Test Plan:
- Receive 0xA9: with CLKS_PER_BIT=4, rx idle 8 clocks, then bit groups of 4 clocks each: 0 (start), 1,0,0,1,0,1,0,1 (data), 1 (stop). Expect rx_byte=0xA9 with a single rx_ready pulse, and rx_frame_err=0.
- Frame error: send 0x3C with stop bit 0. Expect rx_frame_err pulse, no rx_ready, rx_byte unchanged. After rx returns high, 0x5A is received correctly.
- False start: rx low for 1 clock during idle. Expect no rx_ready and no rx_frame_err; the receiver then accepts a following valid 0x81 frame.
- Transmit 0x55: one-cycle tx_enable. Expect tx=0,1,0,1,0,1,0,1,0,1, each held 4 clocks. tx_busy is high for exactly 40 clocks from the enable edge, then tx=1.
- Busy ignore: tx_enable with 0x0F, then tx_enable with 0xF0 mid-frame. Expect only 0x0F serialized; a second frame starts only after tx_busy falls, and only if tx_enable is re-asserted.
- Reset mid-operation: assert reset=0 during receiver DATA and transmitter DATA. Expect tx=1, tx_busy=0, rx_ready=0 immediately. After release, a loopback of tx to rx with 0xC3 yields rx_byte=0xC3.
